// File: rtl/alu_mult_sequencer_pkg.sv
// Opcode constants shared by the ALU and every controller that drives it.
package alu_mult_sequencer_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_SLL = 3'b010;
   localparam logic [2:0] OP_SLR = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_SEQ = 3'b101;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU; SLT and SEQ return a zero-extended 1-bit flag.
module alu
   import alu_mult_sequencer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] input_a,
   input  logic [WIDTH-1:0] input_b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] out
);

   always_comb begin
      out = '0;
      case (op)
         OP_ADD:  out = input_a + input_b;
         OP_SUB:  out = input_a - input_b;
         OP_SLL:  out = input_a << input_b;
         OP_SLR:  out = input_a >> input_b;
         OP_SLT:  out = WIDTH'(input_a < input_b);
         OP_SEQ:  out = WIDTH'(input_a == input_b);
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/alu_mult_sequencer.sv
// Shift-add multiplier that borrows the shared ALU for every arithmetic step;
// product is the low WIDTH bits of multa*multb.
module alu_mult_sequencer
   import alu_mult_sequencer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] multa,
   input  logic [WIDTH-1:0] multb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic [WIDTH-1:0] alua,
   output logic [WIDTH-1:0] alub,
   output logic [2:0]       aluop,
   input  logic [WIDTH-1:0] aluout
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_TEST = 3'd1;
   localparam logic [2:0] S_ADD  = 3'd2;
   localparam logic [2:0] S_SHL  = 3'd3;
   localparam logic [2:0] S_SHR  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]       state_reg,  state_next;
   logic [WIDTH-1:0] acc_reg,    acc_next;
   logic [WIDTH-1:0] mcand_reg,  mcand_next;
   logic [WIDTH-1:0] mplier_reg, mplier_next;
   logic [CNT_W-1:0] iter_reg,   iter_next;

   always_comb begin
      state_next  = state_reg;
      acc_next    = acc_reg;
      mcand_next  = mcand_reg;
      mplier_next = mplier_reg;
      iter_next   = iter_reg;
      alua        = '0;
      alub        = '0;
      aluop       = OP_ADD;
      case (state_reg)
         S_IDLE, S_DONE: begin
            if (start) begin
               mcand_next  = multa;
               mplier_next = multb;
               acc_next    = '0;
               iter_next   = '0;
               state_next  = S_TEST;
            end else begin
               state_next  = S_IDLE;
            end
         end
         S_TEST: begin
            // SEQ against zero: the ALU tells us when the multiplier is exhausted
            aluop = OP_SEQ;
            alua  = mplier_reg;
            alub  = '0;
            if (aluout == WIDTH'(1) || iter_reg == CNT_W'(WIDTH))
               state_next = S_DONE;
            else if (mplier_reg[0])
               state_next = S_ADD;
            else
               state_next = S_SHL;
         end
         S_ADD: begin
            aluop      = OP_ADD;
            alua       = acc_reg;
            alub       = mcand_reg;
            acc_next   = aluout;
            state_next = S_SHL;
         end
         S_SHL: begin
            aluop      = OP_SLL;
            alua       = mcand_reg;
            alub       = WIDTH'(1);
            mcand_next = aluout;
            state_next = S_SHR;
         end
         S_SHR: begin
            aluop       = OP_SLR;
            alua        = mplier_reg;
            alub        = WIDTH'(1);
            mplier_next = aluout;
            iter_next   = iter_reg + CNT_W'(1);
            state_next  = S_TEST;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         iter_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_next;
         mplier_reg <= mplier_next;
         iter_reg   <= iter_next;
      end
   end

   assign busy    = (state_reg != S_IDLE) && (state_reg != S_DONE);
   assign done    = (state_reg == S_DONE);
   assign product = acc_reg;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench: sequencer wired to the shared ALU, expected product and
// Done latency queued at Start and checked when Done appears.
module tb_alu_mult_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] multa, multb, product, alua, alub, aluout;
   logic       busy, done;
   logic [2:0] aluop;

   typedef struct {
      logic [7:0] prod;
      int         lat;
   } exp_t;

   exp_t       sb_q[$];
   logic [2:0] op_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   alu_mult_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .multa   (multa),
      .multb   (multb),
      .busy    (busy),
      .done    (done),
      .product (product),
      .alua    (alua),
      .alub    (alub),
      .aluop   (aluop),
      .aluout  (aluout)
   );

   alu #(.WIDTH(8)) u_alu (
      .input_a (alua),
      .input_b (alub),
      .op      (aluop),
      .out     (aluout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_latency(input logic [7:0] b);
      int k = 0;
      int p = 0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            k = i + 1;
            p++;
         end
      end
      return 3 * k + p + 2;
   endfunction

   task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
      exp_t        e;
      logic [15:0] full;
      full   = a * b;
      e.prod = full[7:0];
      e.lat  = model_latency(b);
      sb_q.push_back(e);
   endtask

   task automatic start_op(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      multa = a;
      multb = b;
      start = 1'b1;
      push_exp(a, b);
   endtask

   // Counts cycles after the accepting edge until Done; optionally pokes Start
   // while busy (glitch) or holds Start in the Done cycle (restart).
   task automatic wait_done(input bit glitch, input bit restart,
                            input logic [7:0] ra, input logic [7:0] rb);
      int   cyc  = 0;
      bit   seen = 0;
      exp_t e;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (glitch && cyc == 4) begin
            multa = 8'h55;
            multb = 8'h33;
            start = 1'b1;
         end
         if (op_q.size() > 0 && !done)
            check("aluop", aluop, op_q.pop_front());
         if (done) begin
            seen = 1;
            e = sb_q.pop_front();
            check("latency", cyc, e.lat);
            check("product", product, e.prod);
            check("busy_at_done", busy, 0);
            $display("[TB] op done: product=%02h cycle=%0d (expected %02h cycle %0d)",
                     product, cyc, e.prod, e.lat);
            if (restart) begin
               multa = ra;
               multb = rb;
               start = 1'b1;
               push_exp(ra, rb);
            end else begin
               @(negedge clk);
               check("done_one_cycle", done, 0);
               check("product_hold", product, e.prod);
            end
         end else begin
            check("busy", busy, 1);
         end
      end
      if (!seen) begin
         check("timeout", seen, 1);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
      op_q.delete();
   endtask

   initial begin
      logic [2:0] seq35 [12];
      bit         saw_done;
      seq35 = '{3'b101, 3'b000, 3'b010, 3'b011, 3'b101, 3'b010,
                3'b011, 3'b101, 3'b000, 3'b010, 3'b011, 3'b101};
      reset = 1'b1;
      start = 1'b0;
      multa = '0;
      multb = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_product", product, 0);
      check("rst_aluop", aluop, 0);
      check("rst_alua", alua, 0);
      check("rst_alub", alub, 0);

      start_op(8'h03, 8'h05);
      for (int i = 0; i < 12; i++) op_q.push_back(seq35[i]);
      wait_done(0, 0, 8'h00, 8'h00);

      start_op(8'hFF, 8'hFF);  wait_done(0, 0, 8'h00, 8'h00);
      start_op(8'h10, 8'h10);  wait_done(0, 0, 8'h00, 8'h00);
      start_op(8'h7A, 8'h00);  wait_done(0, 0, 8'h00, 8'h00);
      start_op(8'h7A, 8'h01);  wait_done(0, 0, 8'h00, 8'h00);

      start_op(8'hC3, 8'h0B);  wait_done(1, 0, 8'h00, 8'h00);

      start_op(8'h09, 8'h07);  wait_done(0, 1, 8'h0D, 8'h13);
      wait_done(0, 0, 8'h00, 8'h00);

      // Reset during cycle 5 of 03*05
      start_op(8'h03, 8'h05);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_product", product, 0);
      check("midrst_aluop", aluop, 0);
      reset = 1'b0;
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      saw_done = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) saw_done = 1;
      end
      check("no_done_after_reset", saw_done, 0);
      start_op(8'h02, 8'h06);  wait_done(0, 0, 8'h00, 8'h00);

      for (int r = 0; r < 4; r++) begin
         start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         wait_done(0, 0, 8'h00, 8'h00);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
